bench_ctrl_gen: RTL and testbench
=================================

Name: bench_ctrl_gen

Overview:
Synthesisable run-control generator for processor bring-up and regression benches. It produces the DUT reset pulse and an N-channel button stimulus pattern. It also runs a cycle-timeout watchdog and an instruction-stall watchdog. It sits between the bench clock/reset and the core top, replacing the fixed-period reset, button and timeout tasks with one parametrised, cycle-exact block. Run statistics are exported for end-of-test checks.

Parameters:
NUM_BTN, 4, number of button channels driven
BTN_INIT, 4'b1010, button pattern loaded at reset (width NUM_BTN)
BTN_PERIOD, 16, cycles between button pattern updates (>=1)
RST_CYCLES, 5, cycles o_dut_rst_n held low after i_rst deasserts (>=1)
TIMEOUT_CYCLES, 11500, RUN cycles before timeout (>=1)
STALL_CYCLES, 256, consecutive RUN cycles without i_inst_vld before stall abort (0 = disabled)
CNT_W, 32, width of statistics counters

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_inst_vld  in  1  DUT retired-instruction strobe
i_hold  in  1  pause: freezes all counters and the button pattern while in RUN
o_dut_rst_n  out  1  active-low reset to DUT
o_btn  out  NUM_BTN  button stimulus
o_running  out  1  high in RUN
o_done  out  1  high in DONE
o_timeout  out  1  sticky: timeout caused DONE
o_stall  out  1  sticky: stall caused DONE
o_cycle_cnt  out  CNT_W  RUN cycles elapsed, saturating
o_inst_cnt  out  CNT_W  i_inst_vld pulses seen in RUN, saturating

Behaviour:
- Reset is synchronous and active-high on i_clk.
- Reset values: state=RST, o_dut_rst_n=0, o_btn=BTN_INIT, o_running=0, o_done=0, o_timeout=0, o_stall=0, both counters=0. Internal rst/btn/stall counters=0.
- All outputs are registered. No combinational path from any input to any output.
- FSM RST:
  - o_dut_rst_n=0.
  - Reset counter increments each cycle.
  - When it reaches RST_CYCLES-1, go to RUN next cycle.
  - o_dut_rst_n goes 1 on the same edge that enters RUN.
  - Exactly RST_CYCLES low cycles after the i_rst-deasserted edge.
- FSM RUN:
  - o_running=1.
  - If i_hold=1: no counter or pattern changes, and no watchdog evaluation.
  - Else o_cycle_cnt increments.
  - o_inst_cnt increments when i_inst_vld=1.
  - Button counter increments. At BTN_PERIOD-1 it wraps to 0 and o_btn rotates left by 1 (MSB to LSB).
  - Stall counter clears on i_inst_vld=1, else increments.
- Timeout: a non-hold cycle where o_cycle_cnt==TIMEOUT_CYCLES-1 sets o_timeout and goes to DONE. o_cycle_cnt reads TIMEOUT_CYCLES in DONE.
- Stall: with STALL_CYCLES!=0, a non-hold cycle with i_inst_vld=0 and stall counter==STALL_CYCLES-1 sets o_stall and goes to DONE.
- Simultaneous timeout and stall in one cycle: both flags set.
- An i_inst_vld in the final RUN cycle is still counted.
- FSM DONE:
  - o_done=1, o_running=0.
  - o_dut_rst_n stays 1; o_btn and all counters frozen.
  - Exit only via i_rst.
- i_rst mid-RUN or in DONE returns to RST with reset values next cycle. Sticky flags clear.
- Counter width: counters saturate at all-ones. TIMEOUT_CYCLES must fit in CNT_W.
- NUM_BTN=1: rotate is identity, so the pattern is constant.
- Elaboration error if RST_CYCLES, BTN_PERIOD or TIMEOUT_CYCLES is 0.

Optional Feature:
BENCH_CTRL_LFSR_BTN_EN
- Defined: o_btn update uses a 16-bit Galois LFSR, taps 0xB400, seed 0xACE1, advanced once per button period. o_btn = LFSR[NUM_BTN-1:0]. Reset value is BTN_INIT; the first period update loads the low bits of the advanced seed. The LFSR resets with i_rst and freezes on i_hold and in DONE.
- Undefined: rotate-left pattern as above, with no LFSR logic.

Test Plan:
1. Defaults, i_rst high 3 cycles then low, i_inst_vld=1 every cycle. Require:
   - o_dut_rst_n low exactly 5 cycles after deassert;
   - o_btn 1010 then 0101 after 16 RUN cycles, 1010 after 32;
   - DONE after 11500 RUN cycles with o_timeout=1, o_stall=0, o_cycle_cnt=11500, o_inst_cnt=11500.
2. STALL_CYCLES=8, i_inst_vld pulses 20 cycles then stops. Require o_stall=1 and o_done=1 exactly 8 cycles after the last pulse, o_inst_cnt=20, o_timeout=0.
3. TIMEOUT_CYCLES=10, STALL_CYCLES=10, i_inst_vld=0 throughout. Require both o_timeout and o_stall=1 on the same DONE entry.
4. i_hold=1 for 7 cycles mid-RUN. Require o_cycle_cnt, o_btn and the stall counter unchanged, and timeout entry delayed by exactly 7 cycles.
5. i_rst pulsed at RUN cycle 40, and again in DONE. Require next-cycle reset values: o_btn=1010, counters 0, flags 0, o_dut_rst_n=0 for 5 cycles again.
6. CNT_W=4, TIMEOUT_CYCLES=15, i_inst_vld=1. Require o_inst_cnt saturates at 15 with no wrap. With BENCH_CTRL_LFSR_BTN_EN, o_btn follows the LFSR reference sequence each 16 cycles.

Source files
------------

// File: rtl/bench_ctrl_gen.sv
// Run-control generator: DUT reset pulse, button stimulus, timeout and stall watchdogs.
// Define BENCH_CTRL_LFSR_BTN_EN to drive o_btn from a 16-bit Galois LFSR instead of a rotating pattern.
module bench_ctrl_gen #(
  parameter int                 NUM_BTN        = 4,
  parameter logic [NUM_BTN-1:0] BTN_INIT       = 4'b1010,
  parameter int                 BTN_PERIOD     = 16,
  parameter int                 RST_CYCLES     = 5,
  parameter int                 TIMEOUT_CYCLES = 11500,
  parameter int                 STALL_CYCLES   = 256,
  parameter int                 CNT_W          = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_inst_vld,
  input  logic               i_hold,
  output logic               o_dut_rst_n,
  output logic [NUM_BTN-1:0] o_btn,
  output logic               o_running,
  output logic               o_done,
  output logic               o_timeout,
  output logic               o_stall,
  output logic [CNT_W-1:0]   o_cycle_cnt,
  output logic [CNT_W-1:0]   o_inst_cnt
);

  localparam int RST_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int BTN_W   = (BTN_PERIOD > 1) ? $clog2(BTN_PERIOD) : 1;
  localparam int STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);
  localparam logic [BTN_W-1:0]   BTN_LAST   = BTN_W'((BTN_PERIOD > 0) ? BTN_PERIOD - 1 : 0);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit                 STALL_EN   = (STALL_CYCLES != 0);

  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("bench_ctrl_gen: RST_CYCLES must be >= 1");
  end
  if (BTN_PERIOD < 1) begin : g_bad_btn_period
    $error("bench_ctrl_gen: BTN_PERIOD must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bench_ctrl_gen: TIMEOUT_CYCLES must be >= 1");
  end
  if (CNT_W < 31 && TIMEOUT_CYCLES > (1 << CNT_W) - 1) begin : g_bad_cnt_w
    $error("bench_ctrl_gen: TIMEOUT_CYCLES does not fit in CNT_W");
  end

  typedef enum logic [1:0] {
    ST_RST,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [RST_W-1:0]     rst_cnt, rst_cnt_nxt;
  logic [BTN_W-1:0]     btn_cnt, btn_cnt_nxt;
  logic [STALL_W-1:0]   stall_cnt, stall_cnt_nxt;
  logic [NUM_BTN-1:0]   btn_nxt;
  logic [CNT_W-1:0]     cycle_nxt, inst_nxt;
  logic                 dut_rst_n_nxt, timeout_nxt, stall_flag_nxt;
  logic                 timeout_hit, stall_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

`ifdef BENCH_CTRL_LFSR_BTN_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  if (NUM_BTN > 16) begin : g_bad_lfsr_width
    $error("bench_ctrl_gen: LFSR button mode supports NUM_BTN <= 16");
  end

  logic [15:0] lfsr, lfsr_nxt, lfsr_adv;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction
`else
  // MSB wraps into LSB; with a single channel this degenerates to identity.
  function automatic logic [NUM_BTN-1:0] rotl(input logic [NUM_BTN-1:0] b);
    logic [NUM_BTN-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      r[(i + 1) % NUM_BTN] = b[i];
    end
    return r;
  endfunction
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_RST;
      rst_cnt     <= '0;
      btn_cnt     <= '0;
      stall_cnt   <= '0;
      o_dut_rst_n <= 1'b0;
      o_btn       <= BTN_INIT;
      o_running   <= 1'b0;
      o_done      <= 1'b0;
      o_timeout   <= 1'b0;
      o_stall     <= 1'b0;
      o_cycle_cnt <= '0;
      o_inst_cnt  <= '0;
`ifdef BENCH_CTRL_LFSR_BTN_EN
      lfsr        <= LFSR_SEED;
`endif
    end else begin
      state       <= state_nxt;
      rst_cnt     <= rst_cnt_nxt;
      btn_cnt     <= btn_cnt_nxt;
      stall_cnt   <= stall_cnt_nxt;
      o_dut_rst_n <= dut_rst_n_nxt;
      o_btn       <= btn_nxt;
      o_running   <= (state_nxt == ST_RUN);
      o_done      <= (state_nxt == ST_DONE);
      o_timeout   <= timeout_nxt;
      o_stall     <= stall_flag_nxt;
      o_cycle_cnt <= cycle_nxt;
      o_inst_cnt  <= inst_nxt;
`ifdef BENCH_CTRL_LFSR_BTN_EN
      lfsr        <= lfsr_nxt;
`endif
    end
  end

  // Everything holds by default, so DONE and held RUN cycles need no explicit branch.
  always_comb begin
    state_nxt      = state;
    rst_cnt_nxt    = rst_cnt;
    btn_cnt_nxt    = btn_cnt;
    stall_cnt_nxt  = stall_cnt;
    dut_rst_n_nxt  = o_dut_rst_n;
    btn_nxt        = o_btn;
    cycle_nxt      = o_cycle_cnt;
    inst_nxt       = o_inst_cnt;
    timeout_nxt    = o_timeout;
    stall_flag_nxt = o_stall;
    timeout_hit    = 1'b0;
    stall_hit      = 1'b0;
`ifdef BENCH_CTRL_LFSR_BTN_EN
    lfsr_nxt       = lfsr;
    lfsr_adv       = lfsr_step(lfsr);
`endif

    case (state)
      ST_RST: begin
        dut_rst_n_nxt = 1'b0;
        if (rst_cnt == RST_LAST) begin
          state_nxt     = ST_RUN;
          rst_cnt_nxt   = '0;
          dut_rst_n_nxt = 1'b1;
        end else begin
          rst_cnt_nxt = rst_cnt + RST_W'(1);
        end
      end

      ST_RUN: begin
        if (!i_hold) begin
          cycle_nxt = sat_inc(o_cycle_cnt);
          if (i_inst_vld) begin
            inst_nxt = sat_inc(o_inst_cnt);
          end

          if (btn_cnt == BTN_LAST) begin
            btn_cnt_nxt = '0;
`ifdef BENCH_CTRL_LFSR_BTN_EN
            lfsr_nxt    = lfsr_adv;
            btn_nxt     = lfsr_adv[NUM_BTN-1:0];
`else
            btn_nxt     = rotl(o_btn);
`endif
          end else begin
            btn_cnt_nxt = btn_cnt + BTN_W'(1);
          end

          if (i_inst_vld || !STALL_EN) begin
            stall_cnt_nxt = '0;
          end else begin
            stall_cnt_nxt = stall_cnt + STALL_W'(1);
          end

          timeout_hit = (o_cycle_cnt == TO_LAST);
          stall_hit   = STALL_EN && !i_inst_vld && (stall_cnt == STALL_LAST);

          // Both causes may fire together; each flag records its own.
          if (timeout_hit || stall_hit) begin
            state_nxt      = ST_DONE;
            timeout_nxt    = timeout_hit;
            stall_flag_nxt = stall_hit;
          end
        end
      end

      ST_DONE: begin
        dut_rst_n_nxt = 1'b1;
      end

      default: begin
        state_nxt = ST_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_bench_ctrl_gen.sv
// Scoreboard bench for bench_ctrl_gen: seven instances with different parameters share one clock.
// Expected values are queued against absolute cycle tags and checked by an independent monitor.
module tb_bench_ctrl_gen;

  localparam int NDUT = 7;
  localparam int T0   = 8;

`ifdef BENCH_CTRL_LFSR_BTN_EN
  localparam logic [3:0] P1 = 4'b0000;
  localparam logic [3:0] P2 = 4'b1000;
  localparam logic [3:0] P3 = 4'b1100;
`else
  localparam logic [3:0] P1 = 4'b0101;
  localparam logic [3:0] P2 = 4'b1010;
  localparam logic [3:0] P3 = 4'b0101;
`endif

  typedef enum int {F_RSTN, F_BTN, F_RUN, F_DONE, F_TO, F_STALL, F_CYC, F_INST} field_e;

  typedef struct {
    int          tag;
    int          dut;
    field_e      f;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t cur;

  logic [NDUT-1:0] rst_v;
  logic [NDUT-1:0] vld_v;
  logic [NDUT-1:0] hold_v;

  logic        rstn_o [NDUT];
  logic        run_o  [NDUT];
  logic        done_o [NDUT];
  logic        to_o   [NDUT];
  logic        stl_o  [NDUT];
  logic [3:0]  btn_o  [NDUT];
  logic [31:0] cyc_o  [NDUT];
  logic [31:0] inst_o [NDUT];

  // 0 defaults, 1 stall, 2 timeout+stall, 3 hold, 4 saturation, 5 mid-run reset, 6 stall with hold
  function automatic int to_p(input int g);
    case (g)
      2:       return 10;
      3:       return 60;
      4:       return 15;
      5:       return 60;
      default: return 11500;
    endcase
  endfunction

  function automatic int stall_p(input int g);
    case (g)
      1:       return 8;
      2:       return 10;
      3:       return 0;
      5:       return 0;
      6:       return 8;
      default: return 256;
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int CW = (g == 4) ? 4 : 32;
    logic [CW-1:0] c_cnt, i_cnt;

    bench_ctrl_gen #(
      .TIMEOUT_CYCLES (to_p(g)),
      .STALL_CYCLES   (stall_p(g)),
      .CNT_W          (CW)
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst_v[g]),
      .i_inst_vld  (vld_v[g]),
      .i_hold      (hold_v[g]),
      .o_dut_rst_n (rstn_o[g]),
      .o_btn       (btn_o[g]),
      .o_running   (run_o[g]),
      .o_done      (done_o[g]),
      .o_timeout   (to_o[g]),
      .o_stall     (stl_o[g]),
      .o_cycle_cnt (c_cnt),
      .o_inst_cnt  (i_cnt)
    );

    assign cyc_o[g]  = 32'(c_cnt);
    assign inst_o[g] = 32'(i_cnt);
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int tag, input int d, input field_e f, input logic [31:0] v);
    exp_t e;
    int   i;
    e.tag = tag;
    e.dut = d;
    e.f   = f;
    e.val = v;
    i = 0;
    while (i < sb.size() && sb[i].tag <= tag) i++;
    sb.insert(i, e);
  endtask

  task automatic push_rst_vals(input int tag, input int d);
    push_exp(tag, d, F_RSTN,  0);
    push_exp(tag, d, F_BTN,   32'b1010);
    push_exp(tag, d, F_RUN,   0);
    push_exp(tag, d, F_DONE,  0);
    push_exp(tag, d, F_TO,    0);
    push_exp(tag, d, F_STALL, 0);
    push_exp(tag, d, F_CYC,   0);
    push_exp(tag, d, F_INST,  0);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] act;
    case (e.f)
      F_RSTN:  act = 32'(rstn_o[e.dut]);
      F_BTN:   act = 32'(btn_o[e.dut]);
      F_RUN:   act = 32'(run_o[e.dut]);
      F_DONE:  act = 32'(done_o[e.dut]);
      F_TO:    act = 32'(to_o[e.dut]);
      F_STALL: act = 32'(stl_o[e.dut]);
      F_CYC:   act = cyc_o[e.dut];
      default: act = inst_o[e.dut];
    endcase
    n_checks++;
    if (act === e.val) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL d%0d.%s @cycle %0d: got %0d, want %0d",
               e.dut, e.f.name(), e.tag, act, e.val);
    end
  endtask

  // Inputs for the edge that ends RUN cycle j (edge T0+j).
  task automatic applyStimulus(input int j);
    rst_v[5]  = (j == 40) || (j == 110);
    vld_v[1]  = (j <= 20);
    vld_v[6]  = (j <= 10);
    hold_v[3] = (j >= 20) && (j <= 26);
    hold_v[6] = (j >= 13) && (j <= 19);
  endtask

  task automatic load_expectations();
    for (int d = 0; d < NDUT; d++) push_rst_vals(3, d);

    push_exp(T0 - 1, 0, F_RSTN, 0);
    push_exp(T0,     0, F_RSTN, 1);
    push_exp(T0,     0, F_RUN,  1);
    push_exp(T0 + 15, 0, F_BTN, 4'b1010);
    push_exp(T0 + 16, 0, F_BTN, P1);
    push_exp(T0 + 32, 0, F_BTN, P2);
`ifdef BENCH_CTRL_LFSR_BTN_EN
    push_exp(T0 + 48, 0, F_BTN, 4'b1100);
    push_exp(T0 + 64, 0, F_BTN, 4'b1110);
`else
    push_exp(T0 + 11510, 0, F_BTN, 4'b1010);
`endif
    push_exp(T0 + 11499, 0, F_DONE,  0);
    push_exp(T0 + 11499, 0, F_CYC,   11499);
    push_exp(T0 + 11500, 0, F_DONE,  1);
    push_exp(T0 + 11500, 0, F_RUN,   0);
    push_exp(T0 + 11500, 0, F_TO,    1);
    push_exp(T0 + 11500, 0, F_STALL, 0);
    push_exp(T0 + 11500, 0, F_CYC,   11500);
    push_exp(T0 + 11500, 0, F_INST,  11500);
    push_exp(T0 + 11500, 0, F_RSTN,  1);
    push_exp(T0 + 11510, 0, F_CYC,   11500);
    push_exp(T0 + 11510, 0, F_DONE,  1);

    push_exp(T0 + 27, 1, F_DONE,  0);
    push_exp(T0 + 28, 1, F_DONE,  1);
    push_exp(T0 + 28, 1, F_STALL, 1);
    push_exp(T0 + 28, 1, F_TO,    0);
    push_exp(T0 + 28, 1, F_INST,  20);
    push_exp(T0 + 28, 1, F_CYC,   28);

    push_exp(T0 + 9,  2, F_DONE,  0);
    push_exp(T0 + 10, 2, F_DONE,  1);
    push_exp(T0 + 10, 2, F_TO,    1);
    push_exp(T0 + 10, 2, F_STALL, 1);
    push_exp(T0 + 10, 2, F_CYC,   10);
    push_exp(T0 + 10, 2, F_INST,  0);

    push_exp(T0 + 19, 3, F_CYC,  19);
    push_exp(T0 + 26, 3, F_CYC,  19);
    push_exp(T0 + 26, 3, F_INST, 19);
    push_exp(T0 + 26, 3, F_BTN,  P1);
    push_exp(T0 + 27, 3, F_CYC,  20);
    push_exp(T0 + 38, 3, F_BTN,  P1);
    push_exp(T0 + 39, 3, F_BTN,  P2);
    push_exp(T0 + 66, 3, F_DONE, 0);
    push_exp(T0 + 67, 3, F_DONE, 1);
    push_exp(T0 + 67, 3, F_TO,   1);
    push_exp(T0 + 67, 3, F_CYC,  60);
    push_exp(T0 + 67, 3, F_INST, 60);
    push_exp(T0 + 67, 3, F_BTN,  P3);

    push_exp(T0 + 14, 4, F_INST, 14);
    push_exp(T0 + 15, 4, F_INST, 15);
    push_exp(T0 + 15, 4, F_DONE, 1);
    push_exp(T0 + 15, 4, F_TO,   1);
    push_exp(T0 + 15, 4, F_CYC,  15);
    push_exp(T0 + 20, 4, F_INST, 15);
    push_exp(T0 + 20, 4, F_CYC,  15);

    push_exp(T0 + 39, 5, F_RUN,  1);
    push_exp(T0 + 39, 5, F_CYC,  39);
    push_rst_vals(T0 + 40, 5);
    push_exp(T0 + 44, 5, F_RSTN, 0);
    push_exp(T0 + 45, 5, F_RSTN, 1);
    push_exp(T0 + 45, 5, F_RUN,  1);
    push_exp(T0 + 45, 5, F_CYC,  0);
    push_exp(T0 + 104, 5, F_DONE, 0);
    push_exp(T0 + 105, 5, F_DONE, 1);
    push_exp(T0 + 105, 5, F_TO,   1);
    push_exp(T0 + 105, 5, F_CYC,  60);
    push_exp(T0 + 105, 5, F_INST, 60);
    push_exp(T0 + 109, 5, F_BTN,  P3);
    push_rst_vals(T0 + 110, 5);
    push_exp(T0 + 114, 5, F_RSTN, 0);
    push_exp(T0 + 115, 5, F_RSTN, 1);

    push_exp(T0 + 24, 6, F_DONE,  0);
    push_exp(T0 + 25, 6, F_DONE,  1);
    push_exp(T0 + 25, 6, F_STALL, 1);
    push_exp(T0 + 25, 6, F_TO,    0);
    push_exp(T0 + 25, 6, F_CYC,   18);
    push_exp(T0 + 25, 6, F_INST,  10);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag == cyc) begin
      cur = sb.pop_front();
      checkOutput(cur);
    end
  end

  initial begin
    rst_v  = '1;
    vld_v  = 7'b0111001;
    hold_v = '0;
    load_expectations();

    repeat (3) tick();
    rst_v = '0;
    repeat (5) tick();

    for (int j = 1; j <= 11520; j++) begin
      applyStimulus(j);
      tick();
    end
    repeat (2) tick();

    while (sb.size() > 0) begin
      cur = sb.pop_front();
      n_checks++;
      $display("[TB] FAIL d%0d.%s @cycle %0d: never sampled, want %0d",
               cur.dut, cur.f.name(), cur.tag, cur.val);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
